// File: rtl/incr_decr_n_pkg.sv
// Shared op-codes and FSM state encoding for the incr_decr_n register bank.
package incr_decr_pkg;

    // Operation codes carried on the op field of the request bus.
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INCR = 2'b01;
    localparam logic [1:0] OP_DECR = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    // Control FSM states: wait for a request, execute it, hold the result.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_EXEC   = 2'b01,
        S_COMMIT = 2'b10
    } state_e;

    // True for the operations that add something to the current register value.
    function automatic logic is_add_like(input logic [1:0] op);
        return (op == OP_INCR) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/incr_decr_n_if.sv
// Request/commit handshake bus between a requester (master) and incr_decr_n (slave).
interface incr_decr_n_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 4
);
    logic [WIDTH-1:0]         data_in;
    logic [1:0]               op;
    logic [$clog2(NREGS)-1:0] reg_addr;
    logic                     val_op;
    logic                     op_ack;
    logic                     op_commit;
    logic                     commit_ack;
    logic [WIDTH-1:0]         data_out;
    logic                     ovf;

    modport master (
        output data_in, op, reg_addr, val_op, commit_ack,
        input  op_ack, op_commit, data_out, ovf
    );

    modport slave (
        input  data_in, op, reg_addr, val_op, commit_ack,
        output op_ack, op_commit, data_out, ovf
    );
endinterface

// File: rtl/incr_decr_n_datapath.sv
// Register bank, wrap/saturate arithmetic unit and the serial scan chain that
// threads through every bank bit (reg0 bit 0 first, reg NREGS-1 bit WIDTH-1 last).
module incr_decr_n_datapath
    import incr_decr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 4,
    parameter int STEP  = 1,
    parameter int SAT   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_en,
    input  logic [$clog2(NREGS)-1:0] reg_sel,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         operand,
    input  logic                     sen,
    input  logic                     scan_ce,
    input  logic                     sin,
    output logic [WIDTH-1:0]         data_out,
    output logic                     ovf,
    output logic                     sout
);

    // Step widened by one bit so the carry/borrow lands in bit WIDTH.
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] bank_q [NREGS];
    logic [WIDTH-1:0] bank_d [NREGS];
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result;
    logic             carry;

    // Arithmetic unit: compute the result and overflow flag for the addressed register.
    always_comb begin
        cur    = bank_q[reg_sel];
        addend = (op == OP_ADD) ? {1'b0, operand} : STEP_X;
        sum    = {1'b0, cur} + addend;
        diff   = {1'b0, cur} - STEP_X;
        result = cur;
        carry  = 1'b0;
        if (op == OP_LOAD) begin
            result = operand;
            carry  = 1'b0;
        end else if (is_add_like(op)) begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            if ((SAT != 0) && carry) begin
                result = '1;
            end
        end else begin
            result = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
            if ((SAT != 0) && carry) begin
                result = '0;
            end
        end
    end

    // Bank next state: scan shift has priority, otherwise the EXEC write.
    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            bank_d[k] = bank_q[k];
        end
        if (sen) begin
            if (scan_ce) begin
                bank_d[0] = {bank_q[0][WIDTH-2:0], sin};
                for (int k = 1; k < NREGS; k++) begin
                    bank_d[k] = {bank_q[k][WIDTH-2:0], bank_q[k-1][WIDTH-1]};
                end
            end
        end else if (reg_en) begin
            bank_d[reg_sel] = result;
        end
    end

    // Result/overflow registers capture only on a real (non-scan) execute cycle.
    always_comb begin
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        if (reg_en && !sen) begin
            data_out_d = result;
            ovf_d      = carry;
        end
    end

    // Bank and result registers; everything clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREGS; k++) begin
                bank_q[k] <= '0;
            end
            data_out_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                bank_q[k] <= bank_d[k];
            end
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
        end
    end

    assign data_out = data_out_q;
    assign ovf      = ovf_q;
    assign sout     = bank_q[NREGS-1][WIDTH-1];

endmodule

// File: rtl/incr_decr_n.sv
// incr_decr_n top: request/commit FSM around the register-bank datapath.
// Scan enable freezes the FSM and all handshake outputs while the chain shifts.
module incr_decr_n
    import incr_decr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 4,
    parameter int STEP  = 1,
    parameter int SAT   = 0
) (
    input  logic          clk,
    input  logic          reset,
    incr_decr_n_if.slave  bus,
    input  logic          sen,
    input  logic          scan_ce,
    input  logic          sin,
    output logic          sout
);

    state_e                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic [$clog2(NREGS)-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]         operand_q, operand_d;
    logic                     op_ack_q, op_ack_d;
    logic                     op_commit_q, op_commit_d;
    logic                     reg_en;
    logic [WIDTH-1:0]         dp_data_out;
    logic                     dp_ovf;

    // Next-state, request capture and handshake outputs; scan holds everything.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        operand_d   = operand_q;
        op_ack_d    = op_ack_q;
        op_commit_d = op_commit_q;
        reg_en      = 1'b0;
        if (!sen) begin
            op_ack_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.val_op) begin
                        op_d      = bus.op;
                        addr_d    = bus.reg_addr;
                        operand_d = bus.data_in;
                        op_ack_d  = 1'b1;
                        state_d   = S_EXEC;
                    end
                end
                S_EXEC: begin
                    reg_en      = 1'b1;
                    op_commit_d = 1'b1;
                    state_d     = S_COMMIT;
                end
                S_COMMIT: begin
                    if (bus.commit_ack) begin
                        op_commit_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    op_commit_d = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    // State and captured-request registers; reset abandons any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            addr_q      <= '0;
            operand_q   <= '0;
            op_ack_q    <= 1'b0;
            op_commit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            operand_q   <= operand_d;
            op_ack_q    <= op_ack_d;
            op_commit_q <= op_commit_d;
        end
    end

    incr_decr_n_datapath #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .STEP  (STEP),
        .SAT   (SAT)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .reg_en   (reg_en),
        .reg_sel  (addr_q),
        .op       (op_q),
        .operand  (operand_q),
        .sen      (sen),
        .scan_ce  (scan_ce),
        .sin      (sin),
        .data_out (dp_data_out),
        .ovf      (dp_ovf),
        .sout     (sout)
    );

    assign bus.op_ack    = op_ack_q;
    assign bus.op_commit = op_commit_q;
    assign bus.data_out  = dp_data_out;
    assign bus.ovf       = dp_ovf;

endmodule
